// File: rtl/accessory_port.sv
// Accessory-side endpoint of the G-15 PL19/PL20 interface: buffered, strobe-paced
// serial input path and a free-running character deserializer on the output path.
module accessory_port #(
    parameter int unsigned CHAR_BITS  = 5,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 CLOCK,
    input  logic                 rst,
    input  logic                 PL19_START_INPUT,
    input  logic                 PL19_STOP_INPUT,
    input  logic                 PL19_SHIFT_CMD_M20,
    output logic                 PL19_INPUT,
    input  logic                 PL20_OUTPUT,
    input  logic                 PL20_OUTPUT_SHIFT,
    input  logic                 in_wr,
    input  logic [CHAR_BITS-1:0] in_char,
    output logic                 in_full,
    output logic                 in_empty,
    output logic                 armed,
    output logic                 out_valid,
    output logic [CHAR_BITS-1:0] out_char,
    input  logic                 out_rd,
    input  logic                 out_sync,
    input  logic                 status_clr,
    output logic                 in_underrun,
    output logic                 in_overflow,
    output logic                 out_overrun
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CHAR_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHIFT} state_t;

    logic [CHAR_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          fifo_cnt, fifo_cnt_n;
    logic                 push, pop, full_now, fifo_has_data, overflow_ev, underrun_ev;

    state_t               state, state_n;
    logic [CHAR_BITS-1:0] in_sh, in_sh_n;
    logic [CW-1:0]        in_cnt, in_cnt_n;

    logic [CHAR_BITS-1:0] ob_sh, ob_sh_n, ob_word;
    logic [CW-1:0]        ob_cnt, ob_cnt_n;
    logic                 ob_done;

    assign full_now      = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_has_data = (fifo_cnt != '0);

    // Input FSM next state; STOP overrides everything and drops the shifter contents.
    always_comb begin
        state_n     = state;
        in_sh_n     = in_sh;
        in_cnt_n    = in_cnt;
        pop         = 1'b0;
        underrun_ev = 1'b0;
        if (PL19_STOP_INPUT) begin
            state_n  = S_IDLE;
            in_sh_n  = '0;
            in_cnt_n = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (PL19_START_INPUT) state_n = S_ARMED;
                end
                S_ARMED: begin
                    underrun_ev = PL19_SHIFT_CMD_M20;
                    if (fifo_has_data) begin
                        pop      = 1'b1;
                        in_sh_n  = fifo_mem[rd_ptr];
                        in_cnt_n = CW'(CHAR_BITS);
                        state_n  = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (PL19_SHIFT_CMD_M20) begin
                        in_sh_n  = in_sh >> 1;
                        in_cnt_n = in_cnt - CW'(1);
                        // Last bit consumed: reload on the same edge so characters abut.
                        if (in_cnt == CW'(1)) begin
                            if (fifo_has_data) begin
                                pop      = 1'b1;
                                in_sh_n  = fifo_mem[rd_ptr];
                                in_cnt_n = CW'(CHAR_BITS);
                            end else begin
                                state_n = S_ARMED;
                            end
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // A write into a full FIFO is still taken when a pop frees the slot on that edge.
    always_comb begin
        push        = in_wr & (~full_now | pop);
        overflow_ev = in_wr & full_now & ~pop;
        fifo_cnt_n  = fifo_cnt + (PW+1)'(push) - (PW+1)'(pop);
    end

    // Output deserializer: bits arrive LSB first and enter at the MSB.
    always_comb begin
        ob_sh_n  = ob_sh;
        ob_cnt_n = ob_cnt;
        ob_done  = 1'b0;
        ob_word  = ob_sh >> 1;
        ob_word[CHAR_BITS-1] = PL20_OUTPUT;
        if (out_sync) begin
            ob_sh_n  = '0;
            ob_cnt_n = '0;
        end else if (PL20_OUTPUT_SHIFT) begin
            ob_sh_n = ob_word;
            if (ob_cnt == CW'(CHAR_BITS - 1)) begin
                ob_done  = 1'b1;
                ob_cnt_n = '0;
            end else begin
                ob_cnt_n = ob_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) fifo_mem[wr_ptr] <= in_char;
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            state       <= S_IDLE;
            in_sh       <= '0;
            in_cnt      <= '0;
            ob_sh       <= '0;
            ob_cnt      <= '0;
            PL19_INPUT  <= 1'b0;
            armed       <= 1'b0;
            in_full     <= 1'b0;
            in_empty    <= 1'b1;
            out_valid   <= 1'b0;
            out_char    <= '0;
            in_underrun <= 1'b0;
            in_overflow <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_cnt   <= fifo_cnt_n;
            state      <= state_n;
            in_sh      <= in_sh_n;
            in_cnt     <= in_cnt_n;
            ob_sh      <= ob_sh_n;
            ob_cnt     <= ob_cnt_n;
            PL19_INPUT <= (state_n == S_SHIFT) & in_sh_n[0];
            armed      <= (state_n != S_IDLE);
            in_full    <= (fifo_cnt_n == (PW+1)'(FIFO_DEPTH));
            in_empty   <= (fifo_cnt_n == '0) && (state_n != S_SHIFT);
            if (ob_done && (!out_valid || out_rd)) begin
                out_valid <= 1'b1;
                out_char  <= ob_word;
            end else if (out_rd) begin
                out_valid <= 1'b0;
            end
            in_underrun <= (in_underrun & ~status_clr) | underrun_ev;
            in_overflow <= (in_overflow & ~status_clr) | overflow_ev;
            out_overrun <= (out_overrun & ~status_clr) | (ob_done & out_valid & ~out_rd);
        end
    end

endmodule

// File: tb/tb_accessory_port.sv
// Directed + randomized bench for accessory_port against a queue-based character model.
module tb_accessory_port;

    localparam int CB    = 5;
    localparam int DEPTH = 8;

    logic          CLOCK = 1'b0;
    logic          rst = 1'b1;
    logic          PL19_START_INPUT = 1'b0, PL19_STOP_INPUT = 1'b0, PL19_SHIFT_CMD_M20 = 1'b0;
    logic          PL19_INPUT;
    logic          PL20_OUTPUT = 1'b0, PL20_OUTPUT_SHIFT = 1'b0;
    logic          in_wr = 1'b0;
    logic [CB-1:0] in_char = '0;
    logic          in_full, in_empty, armed, out_valid;
    logic [CB-1:0] out_char;
    logic          out_rd = 1'b0, out_sync = 1'b0, status_clr = 1'b0;
    logic          in_underrun, in_overflow, out_overrun;

    accessory_port #(.CHAR_BITS(CB), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK), .rst(rst),
        .PL19_START_INPUT(PL19_START_INPUT), .PL19_STOP_INPUT(PL19_STOP_INPUT),
        .PL19_SHIFT_CMD_M20(PL19_SHIFT_CMD_M20), .PL19_INPUT(PL19_INPUT),
        .PL20_OUTPUT(PL20_OUTPUT), .PL20_OUTPUT_SHIFT(PL20_OUTPUT_SHIFT),
        .in_wr(in_wr), .in_char(in_char), .in_full(in_full), .in_empty(in_empty),
        .armed(armed), .out_valid(out_valid), .out_char(out_char), .out_rd(out_rd),
        .out_sync(out_sync), .status_clr(status_clr), .in_underrun(in_underrun),
        .in_overflow(in_overflow), .out_overrun(out_overrun)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: FIFO of characters, bits of the character on the wire, output accumulator.
    int mfifo[$];
    int cur[$];
    int m_acc = 0, m_n = 0, m_char = 0;
    bit m_valid = 0, m_ovr = 0;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_cur();
        int c;
        c = mfifo.pop_front();
        for (int b = 0; b < CB; b++) cur.push_back((c >> b) & 1);
    endtask

    task automatic push_char(input int c);
        in_wr = 1'b1;
        in_char = CB'(c);
        tick();
        in_wr = 1'b0;
        if (mfifo.size() < DEPTH) mfifo.push_back(c);
    endtask

    task automatic pulse_start();
        PL19_START_INPUT = 1'b1; tick(); PL19_START_INPUT = 1'b0;
    endtask

    task automatic pulse_stop();
        PL19_STOP_INPUT = 1'b1; tick(); PL19_STOP_INPUT = 1'b0;
        cur.delete();
    endtask

    // Consecutive shift strobes; the bit on the wire is checked before each one.
    task automatic run_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            if (cur.size() == 0) load_cur();
            chk("pl19_bit", 32'(PL19_INPUT), 32'(cur.pop_front()));
            PL19_SHIFT_CMD_M20 = 1'b1;
            tick();
        end
        PL19_SHIFT_CMD_M20 = 1'b0;
    endtask

    // Strobes with random gaps until the model has no more bits.
    task automatic drain();
        int guard = 0;
        while ((cur.size() > 0 || mfifo.size() > 0) && guard < 2000) begin
            if (cur.size() == 0) load_cur();
            guard++;
            if ($urandom_range(0, 1) == 1) begin
                chk("pl19_rand_bit", 32'(PL19_INPUT), 32'(cur.pop_front()));
                PL19_SHIFT_CMD_M20 = 1'b1;
                tick();
                PL19_SHIFT_CMD_M20 = 1'b0;
            end else begin
                chk("pl19_hold", 32'(PL19_INPUT), 32'(cur[0]));
                tick();
            end
        end
        if (guard >= 2000) begin
            n_checks++;
            n_err++;
            $error("FAIL drain_timeout observed=%0d expected<2000", guard);
        end
    endtask

    // One output-path cycle, then model update and comparison.
    task automatic out_step(input bit sh, input bit b, input bit rd, input bit sync, input bit clr);
        bit done;
        PL20_OUTPUT_SHIFT = sh; PL20_OUTPUT = b; out_rd = rd; out_sync = sync; status_clr = clr;
        tick();
        PL20_OUTPUT_SHIFT = 0; PL20_OUTPUT = 0; out_rd = 0; out_sync = 0; status_clr = 0;
        done = 0;
        if (sync) begin
            m_acc = 0; m_n = 0;
        end else if (sh) begin
            m_acc = m_acc | (int'(b) << m_n);
            m_n++;
            if (m_n == CB) begin
                done = 1;
                m_n = 0;
            end
        end
        if (clr) m_ovr = 0;
        if (done) begin
            if (!m_valid || rd) begin
                m_char = m_acc; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            m_acc = 0;
        end else if (rd) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_char", 32'(out_char), 32'(m_char));
        chk("out_overrun", 32'(out_overrun), 32'(m_ovr));
    endtask

    task automatic out_char_bits(input int c);
        for (int i = 0; i < CB; i++) out_step(1, bit'((c >> i) & 1), 0, 0, 0);
    endtask

    task automatic check_reset();
        chk("rst_pl19", 32'(PL19_INPUT), 0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_full", 32'(in_full), 0);
        chk("rst_empty", 32'(in_empty), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_char", 32'(out_char), 0);
        chk("rst_underrun", 32'(in_underrun), 0);
        chk("rst_overflow", 32'(in_overflow), 0);
        chk("rst_overrun", 32'(out_overrun), 0);
    endtask

    initial begin
        int c;
        // Reset
        tick();
        rst = 1'b0;
        check_reset();

        // Single character 0x15
        push_char(32'h15);
        pulse_start();
        chk("armed_after_start", 32'(armed), 1);
        tick();
        run_strobes(CB);
        chk("t1_armed", 32'(armed), 1);
        chk("t1_empty", 32'(in_empty), 1);
        chk("t1_underrun", 32'(in_underrun), 0);
        chk("t1_pl19_idle", 32'(PL19_INPUT), 0);

        // Back-to-back 0x01, 0x1E
        pulse_stop();
        push_char(32'h01);
        push_char(32'h1E);
        pulse_start();
        tick();
        run_strobes(2 * CB);
        chk("t2_empty", 32'(in_empty), 1);

        // Underrun, and set/clear in the same cycle
        pulse_stop();
        pulse_start();
        PL19_SHIFT_CMD_M20 = 1'b1; tick(); PL19_SHIFT_CMD_M20 = 1'b0;
        chk("t3_underrun", 32'(in_underrun), 1);
        chk("t3_pl19", 32'(PL19_INPUT), 0);
        status_clr = 1'b1; PL19_SHIFT_CMD_M20 = 1'b1; tick();
        status_clr = 1'b0; PL19_SHIFT_CMD_M20 = 1'b0;
        chk("t3_set_beats_clr", 32'(in_underrun), 1);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("t3_cleared", 32'(in_underrun), 0);

        // Fill, overflow, push during full pop, STOP mid-character
        pulse_stop();
        for (int i = 0; i < DEPTH; i++) push_char(int'($urandom_range(0, 31)));
        chk("t4_full", 32'(in_full), 1);
        chk("t4_no_overflow", 32'(in_overflow), 0);
        push_char(32'h1F);
        chk("t4_overflow", 32'(in_overflow), 1);
        chk("t4_still_full", 32'(in_full), 1);
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        chk("t4_ovf_clr", 32'(in_overflow), 0);
        pulse_start();
        load_cur();
        c = int'($urandom_range(0, 31));
        in_wr = 1'b1; in_char = CB'(c); tick(); in_wr = 1'b0;
        mfifo.push_back(c);
        chk("t4_push_pop_full", 32'(in_full), 1);
        chk("t4_push_pop_noovf", 32'(in_overflow), 0);
        run_strobes(2);
        pulse_stop();
        chk("t4_stop_armed", 32'(armed), 0);
        chk("t4_stop_pl19", 32'(PL19_INPUT), 0);
        chk("t4_stop_notempty", 32'(in_empty), 0);
        pulse_start();
        tick();
        run_strobes(CB);
        drain();
        chk("t4_drained_empty", 32'(in_empty), 1);
        chk("t4_drained_full", 32'(in_full), 0);

        // Output path directed
        for (int i = 0; i < CB; i++) out_step(1, bit'((32'h16 >> i) & 1), 0, 0, 0);
        chk("t5_char16", 32'(out_char), 32'h16);
        out_char_bits(int'($urandom_range(0, 31)));
        chk("t5_overrun", 32'(out_overrun), 1);
        out_step(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) out_step(1, bit'($urandom_range(0, 1)), 0, 0, 0);
        out_step(1, 1, 0, 1, 0);
        out_char_bits(32'h0F);
        chk("t6_char0f", 32'(out_char), 32'h0F);

        // Randomized output traffic
        for (int i = 0; i < 150; i++)
            out_step($urandom_range(0, 2) != 0, bit'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 15) == 0);

        // Reset mid-sequence on both paths
        pulse_stop();
        push_char(32'h13);
        push_char(32'h07);
        pulse_start();
        tick();
        run_strobes(2);
        for (int i = 0; i < 3; i++) out_step(1, 1, 0, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        mfifo.delete(); cur.delete();
        m_acc = 0; m_n = 0; m_char = 0; m_valid = 0; m_ovr = 0;
        check_reset();
        out_char_bits(32'h0A);
        chk("post_rst_char", 32'(out_char), 32'h0A);
        push_char(32'h0A);
        pulse_start();
        tick();
        run_strobes(CB);
        chk("post_rst_empty", 32'(in_empty), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
